// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and sizing for the iterative multiply/divide unit.
package muldiv_pkg;
   localparam int W = 32;
   localparam int N = 32;
   localparam int CNT_W = 6;
   typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FIX = 2'b10} state_t;
   function automatic logic is_signed_op(input logic [1:0] op);
      return !op[0];
   endfunction
   function automatic logic is_div_op(input logic [1:0] op);
      return op[1];
   endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one radix-2 step, shift-add multiply or restoring divide on a {upper,lower} accumulator.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter
   import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
   input  logic           is_div,
`endif
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] nxt
);
   logic [W:0] sum;
   logic [2*W-1:0] mul_nxt;
   assign sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : '0);
   assign mul_nxt = {sum, acc[W-1:1]};
`ifdef MULDIV_DIV_EN
   // Partial remainder is 33 bits wide so a borrow shows up in the top bit.
   logic [W:0] rem, diff;
   logic ge;
   assign rem = acc[2*W-1:W-1];
   assign diff = rem - {1'b0, b};
   assign ge = !diff[W];
   assign nxt = is_div ? {(ge ? diff[W-1:0] : rem[W-1:0]), acc[W-2:0], ge} : mul_nxt;
`else
   assign nxt = mul_nxt;
`endif
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers, flush and mthi/mtlo.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete immediately without writing HI/LO.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         flush,
   input  logic         mt_we,
   input  logic         mt_sel,
   input  logic [W-1:0] mt_data,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
   logic dsgn;
   logic [W-1:0] a_r, q, r;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   state_t state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0] acc, nxt, res;
   logic [W-1:0] bmag, amag_in, bmag_in;
   logic neg, div_r, wr;

   assign busy = state != S_IDLE;
   assign amag_in = (is_signed_op(op) && a[W-1]) ? -a : a;
   assign bmag_in = (is_signed_op(op) && b[W-1]) ? -b : b;

   muldiv_iter u_iter (
`ifdef MULDIV_DIV_EN
      .is_div(div_r),
`endif
      .acc(acc),
      .b(bmag),
      .nxt(nxt)
   );

   always_comb begin
      state_n = state;
      if (state != S_IDLE && flush)
         state_n = S_IDLE;
      else if (state == S_IDLE)
         state_n = start ? ((is_div_op(op) && !DIV_EN) ? S_FIX : S_RUN) : S_IDLE;
      else if (state == S_RUN)
         state_n = (cnt == CNT_W'(N - 1)) ? S_FIX : S_RUN;
      else
         state_n = S_IDLE;
   end

   // Sign fixup; divide-by-zero overrides, and the most-negative/-1 case falls out naturally.
   always_comb begin
      res = neg ? -acc : acc;
      wr = 1'b1;
`ifdef MULDIV_DIV_EN
      q = neg ? -acc[W-1:0] : acc[W-1:0];
      r = dsgn ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (div_r)
         res = (bmag == '0) ? {a_r, {W{1'b1}}} : {r, q};
`else
      wr = !div_r;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         done <= 1'b0;
         hi <= '0;
         lo <= '0;
         acc <= '0;
         bmag <= '0;
         neg <= 1'b0;
         div_r <= 1'b0;
`ifdef MULDIV_DIV_EN
         dsgn <= 1'b0;
         a_r <= '0;
`endif
      end else begin
         state <= state_n;
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (start) begin
               acc <= {{W{1'b0}}, amag_in};
               bmag <= bmag_in;
               cnt <= '0;
               neg <= is_signed_op(op) && (a[W-1] ^ b[W-1]);
               div_r <= is_div_op(op);
`ifdef MULDIV_DIV_EN
               dsgn <= is_signed_op(op) && a[W-1];
               a_r <= a;
`endif
            end else if (mt_we) begin
               if (mt_sel)
                  hi <= mt_data;
               else
                  lo <= mt_data;
            end
         end else if (!flush) begin
            if (state == S_RUN) begin
               acc <= nxt;
               cnt <= cnt + CNT_W'(1);
            end else begin
               if (wr)
                  {hi, lo} <= res;
               done <= 1'b1;
            end
         end
      end
   end
endmodule
